apple1_kbd_arbiter: RTL and testbench

//  Shares the Apple 1 PIA keyboard register (KBD/KBDCR) between two character sources: UART RX and PS/2.

---
 rtl/apple1_kbd_arbiter_pkg.sv | 45 ++++
 rtl/apple1_kbd_arbiter_fifo.sv | 68 ++++++
 rtl/apple1_kbd_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_apple1_kbd_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apple1_kbd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apple1_pkg
//   Definitions shared by the Apple 1 keyboard arbiter and its FIFO:
//   - kbd_state_t : presentation FSM states (IDLE / HOLD / GAP)
//   - src_t       : character source selected by the round-robin scheduler
//   - ASCII codes used when filtering bytes at push time
//   - kbd_map()   : the filter/map applied to every byte before it is stored
// ---------------------------------------------------------------------------
package apple1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } kbd_state_t;

  typedef enum logic {
    SRC_UART = 1'b0,
    SRC_PS2  = 1'b1
  } src_t;

  localparam logic [7:0] ASC_NUL    = 8'h00;
  localparam logic [7:0] ASC_BS     = 8'h08;
  localparam logic [7:0] ASC_DEL    = 8'h7F;
  localparam logic [7:0] ASC_RUBOUT = 8'h5F;
  localparam logic [7:0] ASC_LC_A   = 8'h61;
  localparam logic [7:0] ASC_LC_Z   = 8'h7A;
  localparam logic [7:0] ASC_CASE   = 8'h20;

  // Bit 7 of the raw byte is dropped first, so 8'h80 collapses to NUL and
  // is discarded like a plain NUL. Backspace/delete mapping is checked
  // before case folding; the two ranges never overlap.
  function automatic logic [7:0] kbd_map(input logic [7:0] din,
                                         input logic       upcase,
                                         input logic       bs_map);
    logic [7:0] c;
    c = {1'b0, din[6:0]};
    if (bs_map && (c == ASC_BS || c == ASC_DEL))
      c = ASC_RUBOUT;
    else if (upcase && c >= ASC_LC_A && c <= ASC_LC_Z)
      c = c - ASC_CASE;
    return c;
  endfunction

endpackage

// File: rtl/apple1_kbd_arbiter_fifo.sv
// ---------------------------------------------------------------------------
// kbd_fifo
//   Small synchronous 8-bit FIFO, one per character source.
//   Ports:
//     i_clk, i_rst   clock, synchronous active-high reset (empties the FIFO)
//     i_push, i_din  write strobe and byte
//     i_pop          read strobe; o_dout is the head (valid when count != 0)
//     o_full         count == DEPTH
//     o_empty        count == 0
//     o_count        occupancy, 0..DEPTH
//   A push while full is accepted only if a pop happens in the same cycle,
//   so a full FIFO can stream through without dropping. A pop while empty
//   is ignored.
// ---------------------------------------------------------------------------
module kbd_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [7:0]    i_din,
  input  logic          i_pop,
  output logic [7:0]    o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/apple1_kbd_arbiter.sv
// ---------------------------------------------------------------------------
// apple1_kbd_arbiter
//   Shares the Apple 1 PIA keyboard register between a UART receiver and a
//   PS/2 decoder. Each source feeds its own kbd_fifo after filtering; a
//   round-robin scheduler hands one character at a time to the PIA and
//   holds it until the CPU reads KBD, then waits GAP_CYCLES before the next.
//   Ports:
//     clk25, rst               clock, synchronous active-high reset
//     uart_data/uart_valid     UART byte and 1-cycle push strobe
//     ps2_data/ps2_valid       PS/2 ASCII byte and 1-cycle push strobe
//     kbd_read                 1-cycle CPU read of KBD
//     ovf_clr                  clears both overflow flags
//     kbd_data                 presented character, bit 7 forced to 1
//     kbd_ready                KBDCR bit 7, character waiting
//     uart_stop                UART FIFO nearly full (drives CTS)
//     uart_ovf, ps2_ovf        sticky "push dropped" flags
// ---------------------------------------------------------------------------
module apple1_kbd_arbiter
  import apple1_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int UPCASE     = 1,
  parameter int BS_MAP     = 1,
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  input  logic [7:0] ps2_data,
  input  logic       ps2_valid,
  input  logic       kbd_read,
  input  logic       ovf_clr,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       uart_stop,
  output logic       uart_ovf,
  output logic       ps2_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // ---------------- filter / map ----------------
  logic [7:0]    w_uart_byte, w_ps2_byte;
  logic          w_uart_push, w_ps2_push;

  assign w_uart_byte = kbd_map(uart_data, UPCASE != 0, BS_MAP != 0);
  assign w_ps2_byte  = kbd_map(ps2_data,  UPCASE != 0, BS_MAP != 0);
  assign w_uart_push = uart_valid && (w_uart_byte != ASC_NUL);
  assign w_ps2_push  = ps2_valid  && (w_ps2_byte  != ASC_NUL);

  // ---------------- source FIFOs ----------------
  logic [7:0]    w_uart_head, w_ps2_head;
  logic          w_uart_full, w_ps2_full;
  logic          w_uart_empty, w_ps2_empty;
  logic [CW-1:0] w_uart_count;
  logic          w_pop_uart, w_pop_ps2;

  // PS/2 occupancy is only needed inside its FIFO; the empty/full flags
  // cover everything the scheduler looks at.
  kbd_fifo #(.DEPTH(DEPTH)) u_fifo_uart (
    .i_clk   (clk25),
    .i_rst   (rst),
    .i_push  (w_uart_push),
    .i_din   (w_uart_byte),
    .i_pop   (w_pop_uart),
    .o_dout  (w_uart_head),
    .o_full  (w_uart_full),
    .o_empty (w_uart_empty),
    .o_count (w_uart_count)
  );

  logic [CW-1:0] w_ps2_count;

  kbd_fifo #(.DEPTH(DEPTH)) u_fifo_ps2 (
    .i_clk   (clk25),
    .i_rst   (rst),
    .i_push  (w_ps2_push),
    .i_din   (w_ps2_byte),
    .i_pop   (w_pop_ps2),
    .o_dout  (w_ps2_head),
    .o_full  (w_ps2_full),
    .o_empty (w_ps2_empty),
    .o_count (w_ps2_count)
  );

  // ---------------- round-robin scheduler ----------------
  src_t       r_last_src;
  src_t       w_grant;
  logic       w_any;
  logic [7:0] w_head;

  assign w_any = !w_uart_empty || !w_ps2_empty;

  always_comb begin
    w_grant = SRC_UART;
    if (!w_uart_empty && !w_ps2_empty)
      w_grant = (r_last_src == SRC_UART) ? SRC_PS2 : SRC_UART;
    else if (!w_ps2_empty)
      w_grant = SRC_PS2;
  end

  assign w_head = (w_grant == SRC_UART) ? w_uart_head : w_ps2_head;

  // ---------------- presentation FSM ----------------
  kbd_state_t    r_state, w_next_state;
  logic [GW-1:0] r_gap_cnt;
  logic          w_gap_done;
  logic          w_load;
  logic          w_clear;

  assign w_gap_done = (int'(r_gap_cnt) >= GAP_CYCLES - 1);

  always_ff @(posedge clk25) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any)      w_next_state = ST_HOLD;
      ST_HOLD: if (kbd_read)   w_next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      ST_GAP:  if (w_gap_done) w_next_state = ST_IDLE;
      default:                 w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    w_load     = (r_state == ST_IDLE) && w_any;
    w_clear    = (r_state == ST_HOLD) && kbd_read;
    w_pop_uart = w_load && (w_grant == SRC_UART);
    w_pop_ps2  = w_load && (w_grant == SRC_PS2);
  end

  // ---------------- presented character ----------------
  // r_last_src resets to PS/2 so that the first contested grant goes to UART.
  always_ff @(posedge clk25) begin
    if (rst) begin
      kbd_data   <= 8'h00;
      kbd_ready  <= 1'b0;
      r_last_src <= SRC_PS2;
    end else if (w_load) begin
      kbd_data   <= {1'b1, w_head[6:0]};
      kbd_ready  <= 1'b1;
      r_last_src <= w_grant;
    end else if (w_clear) begin
      kbd_ready  <= 1'b0;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst || r_state != ST_GAP) r_gap_cnt <= '0;
    else                          r_gap_cnt <= r_gap_cnt + GW'(1);
  end

  // ---------------- overflow flags / flow control ----------------
  // A push that finds the FIFO full is dropped unless a pop frees a slot
  // in the same cycle. Setting beats a simultaneous clear.
  logic w_uart_drop, w_ps2_drop;

  assign w_uart_drop = w_uart_push && w_uart_full && !w_pop_uart;
  assign w_ps2_drop  = w_ps2_push  && w_ps2_full  && !w_pop_ps2;

  always_ff @(posedge clk25) begin
    if (rst) begin
      uart_ovf <= 1'b0;
      ps2_ovf  <= 1'b0;
    end else begin
      if (w_uart_drop)  uart_ovf <= 1'b1;
      else if (ovf_clr) uart_ovf <= 1'b0;
      if (w_ps2_drop)   ps2_ovf  <= 1'b1;
      else if (ovf_clr) ps2_ovf  <= 1'b0;
    end
  end

  assign uart_stop = (w_uart_count >= CW'(DEPTH - 1));

endmodule

// File: tb/tb_apple1_kbd_arbiter.sv
module tb_apple1_kbd_arbiter;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;

  logic       clk25 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] uart_data = 8'h00;
  logic       uart_valid = 1'b0;
  logic [7:0] ps2_data = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       kbd_read = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       uart_stop;
  logic       uart_ovf;
  logic       ps2_ovf;

  int checks = 0;
  int failures = 0;

  apple1_kbd_arbiter #(.DEPTH(DEPTH), .UPCASE(1), .BS_MAP(1), .GAP_CYCLES(GAP)) dut (
    .clk25(clk25), .rst(rst),
    .uart_data(uart_data), .uart_valid(uart_valid),
    .ps2_data(ps2_data), .ps2_valid(ps2_valid),
    .kbd_read(kbd_read), .ovf_clr(ovf_clr),
    .kbd_data(kbd_data), .kbd_ready(kbd_ready),
    .uart_stop(uart_stop), .uart_ovf(uart_ovf), .ps2_ovf(ps2_ovf)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic       src;       // 0 = UART, 1 = PS/2
    logic [7:0] din;
    logic       exp_rdy;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and the
  // single-cycle strobes are dropped there.
  task automatic tick();
    @(posedge clk25);
    #1;
    uart_valid = 1'b0;
    ps2_valid  = 1'b0;
    kbd_read   = 1'b0;
    ovf_clr    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_uart(input logic [7:0] b);
    uart_data = b; uart_valid = 1'b1;
  endtask

  task automatic push_ps2(input logic [7:0] b);
    ps2_data = b; ps2_valid = 1'b1;
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!kbd_ready && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_ready"}, {31'd0, kbd_ready}, 32'd1);
  endtask

  task automatic get_char(input string nm, input logic [7:0] exp);
    wait_ready(nm);
    chk({nm, "_data"}, {24'd0, kbd_data}, {24'd0, exp});
    kbd_read = 1'b1;
    tick();
    chk({nm, "_rdlo"}, {31'd0, kbd_ready}, 32'd0);
  endtask

  // Returns number of low cycles seen (capped at 20) after a read.
  task automatic low_run(output int low);
    low = 0;
    while (!kbd_ready && low < 20) begin
      low++;
      tick();
    end
  endtask

  // First byte goes straight to the PIA register, the other four fill the FIFO.
  task automatic fill5(input logic [7:0] base);
    for (int k = 0; k < 5; k++) begin
      push_uart(base + 8'(k));
      tick();
    end
  endtask

  initial begin
    int low;
    vecs[0] = '{"upper_A",  1'b0, 8'h41, 1'b1, 8'hC1};
    vecs[1] = '{"ps2_lc_a", 1'b1, 8'h61, 1'b1, 8'hC1};
    vecs[2] = '{"uart_del", 1'b0, 8'h7F, 1'b1, 8'hDF};
    vecs[3] = '{"ps2_bs",   1'b1, 8'h08, 1'b1, 8'hDF};
    vecs[4] = '{"nul_drop", 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[5] = '{"ps2_lc_z", 1'b1, 8'h7A, 1'b1, 8'hDA};
    vecs[6] = '{"bit7_ign", 1'b0, 8'hE1, 1'b1, 8'hC1};
    vecs[7] = '{"brace",    1'b0, 8'h7B, 1'b1, 8'hFB};
    vecs[8] = '{"bqoute",   1'b1, 8'h60, 1'b1, 8'hE0};
    vecs[9] = '{"under",    1'b0, 8'h5F, 1'b1, 8'hDF};

    // Reset state
    do_reset();
    chk("rst_data", {24'd0, kbd_data}, 32'h00);
    chk("rst_ready", {31'd0, kbd_ready}, 32'd0);
    chk("rst_stop", {31'd0, uart_stop}, 32'd0);
    chk("rst_uovf", {31'd0, uart_ovf}, 32'd0);
    chk("rst_povf", {31'd0, ps2_ovf}, 32'd0);

    // Single-character vectors: latency, mapping, read handshake
    for (int i = 0; i < 10; i++) begin
      do_reset();
      if (vecs[i].src) push_ps2(vecs[i].din);
      else             push_uart(vecs[i].din);
      tick();
      chk({vecs[i].name, "_lat"}, {31'd0, kbd_ready}, 32'd0);
      tick();
      chk({vecs[i].name, "_rdy"}, {31'd0, kbd_ready}, {31'd0, vecs[i].exp_rdy});
      chk({vecs[i].name, "_dat"}, {24'd0, kbd_data}, {24'd0, vecs[i].exp_data});
      kbd_read = 1'b1;
      tick();
      chk({vecs[i].name, "_rd"}, {31'd0, kbd_ready}, 32'd0);
    end

    // Round robin: U/P pushed together three times
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push_uart(8'h55);
      push_ps2(8'h50);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      wait_ready("rr");
      chk($sformatf("rr_ord%0d", i), {24'd0, kbd_data}, (i % 2 == 0) ? 32'hD5 : 32'hD0);
      kbd_read = 1'b1;
      tick();
      low_run(low);
      if (i < 5) chk($sformatf("rr_gap%0d", i), low, GAP + 1);
      else       chk("rr_tail", low, 20);
    end

    // Overflow, CTS, ovf_clr, drain order
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push_uart(8'h31 + 8'(k));
      tick();
      chk($sformatf("stop_k%0d", k), {31'd0, uart_stop}, (k >= 3) ? 32'd1 : 32'd0);
    end
    chk("full_noovf", {31'd0, uart_ovf}, 32'd0);
    push_uart(8'h36);
    tick();
    chk("ovf_set", {31'd0, uart_ovf}, 32'd1);
    chk("ovf_ps2_quiet", {31'd0, ps2_ovf}, 32'd0);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", {31'd0, uart_ovf}, 32'd0);
    push_uart(8'h37);
    ovf_clr = 1'b1;
    tick();
    chk("ovf_set_wins", {31'd0, uart_ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    for (int k = 0; k < 5; k++)
      get_char($sformatf("drain%0d", k), 8'hB1 + 8'(k));
    low_run(low);
    chk("drain_end", low, 20);
    chk("drain_stop", {31'd0, uart_stop}, 32'd0);

    // Push and pop on a full FIFO in the same cycle
    do_reset();
    fill5(8'h41);
    kbd_read = 1'b1;
    tick();                 // HOLD -> GAP
    tick();
    tick();                 // GAP -> IDLE
    push_uart(8'h46);
    tick();                 // pop 'B' and push 'F' together
    chk("pp_ready", {31'd0, kbd_ready}, 32'd1);
    chk("pp_data", {24'd0, kbd_data}, 32'hC2);
    chk("pp_count", {28'd0, dut.w_uart_count}, 32'd4);
    chk("pp_noovf", {31'd0, uart_ovf}, 32'd0);
    for (int k = 0; k < 5; k++)
      get_char($sformatf("pp_drain%0d", k), 8'hC2 + 8'(k));

    // PS/2 overflow
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push_ps2(8'h30 + 8'(k));
      tick();
    end
    chk("povf_set", {31'd0, ps2_ovf}, 32'd1);
    chk("povf_uart_quiet", {31'd0, uart_ovf}, 32'd0);
    chk("povf_nostop", {31'd0, uart_stop}, 32'd0);

    // Reset during HOLD with characters queued
    do_reset();
    push_uart(8'h41); tick();
    push_uart(8'h42); tick();
    push_uart(8'h43); tick();
    chk("hr_hold", {31'd0, kbd_ready}, 32'd1);
    rst = 1'b1;
    tick();
    chk("hr_ready", {31'd0, kbd_ready}, 32'd0);
    chk("hr_data", {24'd0, kbd_data}, 32'h00);
    rst = 1'b0;
    low_run(low);
    chk("hr_quiet", low, 20);
    chk("hr_count", {28'd0, dut.w_uart_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
